// File: rtl/clap_energy_window.sv
// clap_energy_window
// Multichannel sliding-window energy stage for the clap-detection chain.
// Each channel keeps its own ring of biased squares, a running sum and a
// decimation counter; one shared datapath processes one sample at a time
// through ACCEPT -> SQUARE -> ACCUM (-> OUTPUT when an energy is emitted).
module clap_energy_window #(
    parameter int NUM_CHANNELS = 2,
    parameter int SAMPLE_WIDTH = 16,
    parameter int SIGNAL_BIAS  = -64,
    parameter int DURATION     = 4,
    parameter int DECIMATE     = 1,
    localparam int CH_WIDTH     = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    localparam int SQ_WIDTH     = 2 * SAMPLE_WIDTH + 2,
    localparam int ENERGY_WIDTH = SQ_WIDTH + $clog2(DURATION)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [SAMPLE_WIDTH-1:0] sample_data,
    input  logic [CH_WIDTH-1:0]     sample_channel,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    output logic [ENERGY_WIDTH-1:0] energy_data,
    output logic [CH_WIDTH-1:0]     energy_channel,
    output logic                    energy_valid,
    input  logic                    energy_ready
);

    localparam int PTR_WIDTH  = $clog2(DURATION);
    localparam int FILL_WIDTH = $clog2(DURATION + 1);
    localparam int DEC_WIDTH  = 8;
    localparam int X_WIDTH    = SAMPLE_WIDTH + 2;
    localparam int RAM_DEPTH  = NUM_CHANNELS * DURATION;
    localparam int ADDR_WIDTH = CH_WIDTH + PTR_WIDTH;

    localparam logic [FILL_WIDTH-1:0]     FILL_FULL = FILL_WIDTH'(DURATION);
    localparam logic [PTR_WIDTH-1:0]      PTR_LAST  = PTR_WIDTH'(DURATION - 1);
    localparam logic [DEC_WIDTH-1:0]      DEC_LAST  = DEC_WIDTH'(DECIMATE - 1);
    localparam logic [CH_WIDTH:0]         CH_LIMIT  = (CH_WIDTH + 1)'(NUM_CHANNELS);
    localparam logic signed [X_WIDTH-1:0] BIAS      = X_WIDTH'(SIGNAL_BIAS);

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        SQUARE = 2'd1,
        ACCUM  = 2'd2,
        OUTPUT = 2'd3
    } state_t;

    // Square of the biased sample; the result always fits SQ_WIDTH, so the
    // product is formed directly at that width after sign extension.
    function automatic logic [SQ_WIDTH-1:0] biased_square(input logic [SAMPLE_WIDTH-1:0] raw);
        logic signed [X_WIDTH-1:0]  x;
        logic signed [SQ_WIDTH-1:0] xe;
        x  = $signed({2'b00, raw}) + BIAS;
        xe = SQ_WIDTH'(x);
        return xe * xe;
    endfunction

    state_t                  state_r;
    logic                    sample_ready_r;
    logic                    energy_valid_r;
    logic [ENERGY_WIDTH-1:0] energy_data_r;
    logic [CH_WIDTH-1:0]     energy_channel_r;

    logic [SAMPLE_WIDTH-1:0] sample_r;
    logic [CH_WIDTH-1:0]     ch_r;
    logic [SQ_WIDTH-1:0]     sq_r;
    logic [SQ_WIDTH-1:0]     oldest_r;

    logic [FILL_WIDTH-1:0]   fill_r [NUM_CHANNELS];
    logic [PTR_WIDTH-1:0]    ptr_r  [NUM_CHANNELS];
    logic [ENERGY_WIDTH-1:0] sum_r  [NUM_CHANNELS];
    logic [DEC_WIDTH-1:0]    dec_r  [NUM_CHANNELS];

    logic [SQ_WIDTH-1:0]     ring_r [RAM_DEPTH];

    logic [ADDR_WIDTH-1:0]   addr_s;
    logic [FILL_WIDTH-1:0]   fill_cur_s;
    logic [FILL_WIDTH-1:0]   fill_new_s;
    logic [PTR_WIDTH-1:0]    ptr_cur_s;
    logic [PTR_WIDTH-1:0]    ptr_new_s;
    logic [DEC_WIDTH-1:0]    dec_cur_s;
    logic [DEC_WIDTH-1:0]    dec_new_s;
    logic [ENERGY_WIDTH-1:0] sum_new_s;
    logic                    full_new_s;
    logic                    emit_s;

    assign sample_ready   = sample_ready_r;
    assign energy_valid   = energy_valid_r;
    assign energy_data    = energy_data_r;
    assign energy_channel = energy_channel_r;

    // Next per-channel state for the latched sample, used in ACCUM.
    always_comb begin
        fill_cur_s = fill_r[ch_r];
        ptr_cur_s  = ptr_r[ch_r];
        dec_cur_s  = dec_r[ch_r];
        addr_s     = {ch_r, ptr_cur_s};
        fill_new_s = fill_cur_s;
        sum_new_s  = sum_r[ch_r];
        ptr_new_s  = ptr_cur_s;
        dec_new_s  = dec_cur_s;
        full_new_s = 1'b0;
        emit_s     = 1'b0;

        if (fill_cur_s == FILL_FULL) begin
            fill_new_s = FILL_FULL;
            sum_new_s  = sum_r[ch_r] + ENERGY_WIDTH'(sq_r) - ENERGY_WIDTH'(oldest_r);
        end else begin
            fill_new_s = fill_cur_s + FILL_WIDTH'(1);
            sum_new_s  = sum_r[ch_r] + ENERGY_WIDTH'(sq_r);
        end

        if (ptr_cur_s == PTR_LAST) begin
            ptr_new_s = '0;
        end else begin
            ptr_new_s = ptr_cur_s + PTR_WIDTH'(1);
        end

        full_new_s = (fill_new_s == FILL_FULL);
        emit_s     = full_new_s && (dec_cur_s == DEC_WIDTH'(0));

        if (full_new_s) begin
            if (dec_cur_s == DEC_LAST) begin
                dec_new_s = '0;
            end else begin
                dec_new_s = dec_cur_s + DEC_WIDTH'(1);
            end
        end else begin
            dec_new_s = dec_cur_s;
        end
    end

    // Ring storage of past squares; never cleared, only read once a window is full.
    always_ff @(posedge clock) begin
        if (!reset && state_r == ACCUM) begin
            ring_r[addr_s] <= sq_r;
        end
    end

    // Control FSM, per-channel window state and registered handshake outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r          <= ACCEPT;
            sample_ready_r   <= 1'b1;
            energy_valid_r   <= 1'b0;
            energy_data_r    <= '0;
            energy_channel_r <= '0;
            sample_r         <= '0;
            ch_r             <= '0;
            sq_r             <= '0;
            oldest_r         <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                fill_r[i] <= '0;
                ptr_r[i]  <= '0;
                sum_r[i]  <= '0;
                dec_r[i]  <= '0;
            end
        end else begin
            case (state_r)
                ACCEPT: begin
                    // Out-of-range channels are consumed and silently dropped.
                    if (sample_valid && ({1'b0, sample_channel} < CH_LIMIT)) begin
                        sample_r       <= sample_data;
                        ch_r           <= sample_channel;
                        sample_ready_r <= 1'b0;
                        state_r        <= SQUARE;
                    end
                end
                SQUARE: begin
                    sq_r     <= biased_square(sample_r);
                    oldest_r <= ring_r[addr_s];
                    state_r  <= ACCUM;
                end
                ACCUM: begin
                    fill_r[ch_r] <= fill_new_s;
                    ptr_r[ch_r]  <= ptr_new_s;
                    sum_r[ch_r]  <= sum_new_s;
                    dec_r[ch_r]  <= dec_new_s;
                    if (emit_s) begin
                        energy_data_r    <= sum_new_s;
                        energy_channel_r <= ch_r;
                        energy_valid_r   <= 1'b1;
                        state_r          <= OUTPUT;
                    end else begin
                        sample_ready_r <= 1'b1;
                        state_r        <= ACCEPT;
                    end
                end
                OUTPUT: begin
                    if (energy_ready) begin
                        energy_valid_r <= 1'b0;
                        sample_ready_r <= 1'b1;
                        state_r        <= ACCEPT;
                    end
                end
                default: begin
                    energy_valid_r <= 1'b0;
                    sample_ready_r <= 1'b1;
                    state_r        <= ACCEPT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clap_energy_window.sv
// Bench for clap_energy_window: unit 0 (2 channels, no decimation) and
// unit 1 (3 channels, decimate by 3) checked against a sample-history model.
module tb_clap_energy_window;

    localparam int     DUR  = 4;
    localparam longint BIAS = -64;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] s_data  [2];
    logic [1:0]  s_ch    [2];
    logic        s_valid [2];
    logic        e_ready [2];
    logic        s_ready [2];
    logic        e_valid [2];
    logic [35:0] e_data  [2];
    logic [1:0]  e_ch    [2];

    logic        a_sready, a_evalid, b_sready, b_evalid;
    logic [35:0] a_edata, b_edata;
    logic [0:0]  a_ech;
    logic [1:0]  b_ech;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct { int unit; int chan; longint val; } rec_t;
    rec_t hist [$];
    rec_t exp_q [$];

    always #5 clk = ~clk;

    clap_energy_window #(.NUM_CHANNELS(2), .SAMPLE_WIDTH(16), .SIGNAL_BIAS(-64),
                         .DURATION(4), .DECIMATE(1)) u_dut_a (
        .clock(clk), .reset(reset),
        .sample_data(s_data[0]), .sample_channel(s_ch[0][0:0]),
        .sample_valid(s_valid[0]), .sample_ready(a_sready),
        .energy_data(a_edata), .energy_channel(a_ech),
        .energy_valid(a_evalid), .energy_ready(e_ready[0])
    );

    clap_energy_window #(.NUM_CHANNELS(3), .SAMPLE_WIDTH(16), .SIGNAL_BIAS(-64),
                         .DURATION(4), .DECIMATE(3)) u_dut_b (
        .clock(clk), .reset(reset),
        .sample_data(s_data[1]), .sample_channel(s_ch[1]),
        .sample_valid(s_valid[1]), .sample_ready(b_sready),
        .energy_data(b_edata), .energy_channel(b_ech),
        .energy_valid(b_evalid), .energy_ready(e_ready[1])
    );

    assign s_ready[0] = a_sready;
    assign s_ready[1] = b_sready;
    assign e_valid[0] = a_evalid;
    assign e_valid[1] = b_evalid;
    assign e_data[0]  = a_edata;
    assign e_data[1]  = b_edata;
    assign e_ch[0]    = {1'b0, a_ech};
    assign e_ch[1]    = b_ech;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int nch_of(input int u);
        return (u == 0) ? 2 : 3;
    endfunction

    function automatic int dec_of(input int u);
        return (u == 0) ? 1 : 3;
    endfunction

    // Reference: energy is the sum of (s+bias)^2 over the last DUR samples of that
    // unit/channel; emit on the DUR-th sample and every dec-th one after it.
    function automatic void model_push(input int u, input int c, input int d,
                                       output bit emit, output longint e);
        int     n;
        longint x;
        emit = 1'b0;
        e    = 0;
        n    = 0;
        hist.push_back('{unit: u, chan: c, val: longint'(d)});
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i].unit == u && hist[i].chan == c) begin
                n++;
                if (n <= DUR) begin
                    x = hist[i].val + BIAS;
                    e += x * x;
                end
            end
        end
        if (n >= DUR && ((n - DUR) % dec_of(u)) == 0) begin
            emit = 1'b1;
            exp_q.push_back('{unit: u, chan: c, val: e});
        end
    endfunction

    function automatic int has_exp(input int u);
        int k = 0;
        foreach (exp_q[i]) if (exp_q[i].unit == u) k++;
        return k;
    endfunction

    // Output monitor: every completed handshake must match the oldest expectation.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (reset === 1'b0 && e_valid[u] === 1'b1 && e_ready[u] === 1'b1) begin
                int idx;
                idx = -1;
                for (int i = 0; i < exp_q.size(); i++)
                    if (idx < 0 && exp_q[i].unit == u) idx = i;
                if (idx < 0) begin
                    check_eq("unexpected_out", 64'd1, 64'd0);
                end else begin
                    check_eq("out_energy", e_data[u], exp_q[idx].val);
                    check_eq("out_chan", e_ch[u], exp_q[idx].chan);
                    exp_q.delete(idx);
                end
            end
        end
    end

    // Offer one sample, check latency pattern; called and returns at posedge+1.
    task automatic accept_one(input int u, input int c, input int d,
                              input longint exp_e, output bit emit);
        bit     dropped;
        longint e;
        int     waited;
        dropped    = (c >= nch_of(u));
        emit       = 1'b0;
        e          = 0;
        s_data[u]  = 16'(d);
        s_ch[u]    = 2'(c);
        s_valid[u] = 1'b1;
        waited     = 0;
        @(negedge clk);
        while (s_ready[u] !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (s_ready[u] !== 1'b1) begin
            check_eq("accept_timeout", 64'd0, 64'd1);
            s_valid[u] = 1'b0;
            return;
        end
        @(posedge clk);
        #1 s_valid[u] = 1'b0;
        if (!dropped) model_push(u, c, d, emit, e);
        @(negedge clk);
        if (dropped) begin
            check_eq("drop_ready", s_ready[u], 1);
            check_eq("drop_valid", e_valid[u], 0);
            @(posedge clk);
            #1;
            return;
        end
        check_eq("busy_ready", s_ready[u], 0);
        check_eq("lat_c1", e_valid[u], 0);
        @(negedge clk);
        check_eq("lat_c2", e_valid[u], 0);
        @(negedge clk);
        check_eq("lat_c3", e_valid[u], emit);
        if (!emit) check_eq("ready_back", s_ready[u], 1);
        if (exp_e >= 0) begin
            check_eq("energy", e_data[u], exp_e);
            check_eq("energy_ch", e_ch[u], c);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic finish_out(input int u, input int stall);
        int waited = 0;
        repeat (stall) @(posedge clk);
        #1 e_ready[u] = 1'b1;
        @(negedge clk);
        while (e_valid[u] === 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check_eq("out_drained", e_valid[u], 0);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int u, input int c, input int d, input int stall, input longint exp_e);
        bit emit;
        e_ready[u] = (stall == 0);
        accept_one(u, c, d, exp_e, emit);
        if (emit) finish_out(u, stall);
    endtask

    task automatic wait_idle(input int u);
        int waited = 0;
        e_ready[u] = 1'b1;
        @(negedge clk);
        while ((has_exp(u) != 0 || s_ready[u] !== 1'b1) && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        check_eq("idle", has_exp(u), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        e_ready[0] = 1'b1;
        e_ready[1] = 1'b1;
        s_valid[0] = 1'b0;
        s_valid[1] = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        hist.delete();
        exp_q.delete();
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check_eq("rst_ready", s_ready[u], 1);
            check_eq("rst_valid", e_valid[u], 0);
            check_eq("rst_data", e_data[u], 0);
            check_eq("rst_chan", e_ch[u], 0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit     emit;
        longint e;
        int     u, c, d;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            s_data[i]  = 16'd0;
            s_ch[i]    = 2'd0;
            s_valid[i] = 1'b0;
            e_ready[i] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        do_reset();

        // Basic window on unit 0, channel 0, then channel independence.
        send(0, 0, 65, 0, -1);
        send(0, 0, 66, 0, -1);
        send(0, 0, 67, 0, -1);
        send(0, 0, 68, 0, 30);
        send(0, 0, 69, 0, 54);
        for (int k = 0; k < 4; k++) send(0, 1, 64, 0, (k == 3) ? 0 : -1);
        send(0, 0, 70, 0, 86);

        // Back-pressure: hold an emit for 10 cycles with the next sample waiting.
        e_ready[0] = 1'b0;
        accept_one(0, 1, 70, 36, emit);
        s_data[0]  = 16'd71;
        s_ch[0]    = 2'd0;
        s_valid[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("stall_valid", e_valid[0], 1);
            check_eq("stall_data", e_data[0], 36);
            check_eq("stall_chan", e_ch[0], 1);
            check_eq("stall_ready", s_ready[0], 0);
        end
        @(posedge clk);
        #1 e_ready[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("reaccept", s_ready[0], 1);
        @(posedge clk);
        #1 s_valid[0] = 1'b0;
        model_push(0, 0, 71, emit, e);
        wait_idle(0);

        // Reset with history and a pending output; windows restart from empty.
        send(0, 0, 200, 0, -1);
        send(0, 0, 300, 0, -1);
        e_ready[0] = 1'b0;
        accept_one(0, 1, 500, -1, emit);
        do_reset();
        for (int k = 0; k < 4; k++) send(0, 0, 0, 0, (k == 3) ? 16384 : -1);
        for (int k = 0; k < 4; k++) send(0, 1, 0, 0, (k == 3) ? 16384 : -1);

        // Decimation by 3 on unit 1, then a dropped out-of-range channel.
        for (int k = 1; k <= 7; k++) send(1, 0, 74, 0, (k == 4 || k == 7) ? 400 : -1);
        send(1, 3, 500, 0, -1);
        for (int k = 0; k < 4; k++) send(1, 2, 80, 0, (k == 3) ? 1024 : -1);

        // Randomized interleaving with random back-pressure.
        for (int i = 0; i < 300; i++) begin
            u = int'($urandom_range(0, 1));
            c = (u == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 3));
            d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535))
                                            : int'($urandom_range(0, 200));
            send(u, c, d, int'($urandom_range(0, 3)), -1);
        end

        wait_idle(0);
        wait_idle(1);
        check_eq("leftover", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
